// File: rtl/lcd_spi_streamer.sv
// Streams D/C-tagged LCD bytes from a small FIFO into an SB_SPI hard core through its
// CPU-side register port: SPISR polling, SPITXDR writes and SPICSR chip-select framing.
module lcd_spi_streamer #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [3:0]  SPI_BASE   = 4'h0,
    parameter int          POLL_MAX   = 1023,
    parameter logic [7:0]  CSR_ON     = 8'hFE,
    parameter logic [7:0]  CSR_OFF    = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_dc,
    input  logic       s_last,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       cs,
    output logic       we,
    output logic [7:0] addr,
    output logic [7:0] din,
    input  logic [7:0] dout,
    input  logic       rdy,
    output logic       lcd_dc,
    output logic       busy,
    output logic       err,
    output logic [3:0] dbg_state
);
    localparam int         AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C   = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] ONE_C     = 1;
    localparam int         POLL_LIM_I = POLL_MAX - 1;
    localparam logic [9:0] POLL_LIM   = POLL_LIM_I[9:0];
    localparam logic [7:0] ADDR_SR    = {SPI_BASE, 4'hC};
    localparam logic [7:0] ADDR_TXDR  = {SPI_BASE, 4'hD};
    localparam logic [7:0] ADDR_CSR   = {SPI_BASE, 4'hF};

    typedef enum logic [3:0] {
        S_IDLE, S_CS_ON, S_DC_CHK, S_TIP_P, S_TRDY_P, S_TX, S_HOLD, S_END_P, S_CS_OFF
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_cs, r_we, r_lcd_dc, r_err;
    logic [7:0]  r_addr, r_din;
    logic [9:0]  r_poll;
    logic        w_cs_nxt, w_we_nxt, w_dc_nxt;
    logic [7:0]  w_addr_nxt, w_din_nxt;
    logic [9:0]  w_poll_nxt;
    logic        w_acc, w_acc_we, w_poll_ok, w_done;
    logic [7:0]  w_acc_addr, w_acc_din;
    logic        w_pop, w_flush, w_err_set;

    // Upstream handshake: a byte is taken on any clock edge where s_valid and s_ready are
    // both high; s_ready depends only on FIFO occupancy, never on s_valid.
    logic [9:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0] r_count;
    logic        w_full, w_empty, w_push;
    logic [9:0]  w_head;
    logic        w_unused;

    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == '0);
    // A push coinciding with a timeout flush is discarded along with the rest of the burst.
    assign w_push   = s_valid & ~w_full & ~w_flush;
    assign w_head   = r_mem[r_rd];
    assign w_done   = r_cs & rdy;
    assign w_unused = ^{dout[6:5], dout[3:0]};

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {s_last, s_dc, s_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_rd    <= r_wr;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cs_nxt    = r_cs;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_din_nxt   = r_din;
        w_dc_nxt    = r_lcd_dc;
        w_poll_nxt  = r_poll;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_err_set   = 1'b0;
        w_acc       = 1'b0;
        w_acc_we    = 1'b0;
        w_acc_addr  = ADDR_SR;
        w_acc_din   = 8'h00;
        w_poll_ok   = 1'b0;
        case (r_state)
            S_IDLE: if (!w_empty) w_state_nxt = S_CS_ON;
            S_CS_ON: begin
                w_acc = 1'b1; w_acc_we = 1'b1; w_acc_addr = ADDR_CSR; w_acc_din = CSR_ON;
                if (w_done) w_state_nxt = S_DC_CHK;
            end
            S_DC_CHK: w_state_nxt = (w_head[8] == r_lcd_dc) ? S_TRDY_P : S_TIP_P;
            S_TIP_P, S_TRDY_P, S_END_P: begin
                w_acc     = 1'b1;
                w_poll_ok = (r_state == S_TRDY_P) ? dout[4] : ~dout[7];
                if (w_done) begin
                    if (w_poll_ok) begin
                        // D/C only moves once the shifter is idle, so no byte sees it change.
                        if (r_state == S_TIP_P) begin
                            w_dc_nxt    = w_head[8];
                            w_state_nxt = S_TRDY_P;
                        end else if (r_state == S_TRDY_P) begin
                            w_state_nxt = S_TX;
                        end else begin
                            w_state_nxt = S_CS_OFF;
                        end
                    end else if (r_poll == POLL_LIM) begin
                        w_err_set   = 1'b1;
                        w_flush     = 1'b1;
                        w_state_nxt = S_CS_OFF;
                    end else begin
                        w_poll_nxt = r_poll + 10'd1;
                    end
                end
            end
            S_TX: begin
                w_acc = 1'b1; w_acc_we = 1'b1; w_acc_addr = ADDR_TXDR; w_acc_din = w_head[7:0];
                if (w_done) begin
                    w_pop = 1'b1;
                    if (w_head[9])              w_state_nxt = S_END_P;
                    else if (r_count > ONE_C)   w_state_nxt = S_DC_CHK;
                    else                        w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: if (!w_empty) w_state_nxt = S_DC_CHK;
            S_CS_OFF: begin
                w_acc = 1'b1; w_acc_we = 1'b1; w_acc_addr = ADDR_CSR; w_acc_din = CSR_OFF;
                if (w_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Access engine: cs rises only from low, so every access is preceded by a low cycle.
        if (w_acc && !r_cs) begin
            w_cs_nxt   = 1'b1;
            w_we_nxt   = w_acc_we;
            w_addr_nxt = w_acc_addr;
            w_din_nxt  = w_acc_din;
        end else if (w_done) begin
            w_cs_nxt = 1'b0;
        end
        if (w_state_nxt != r_state) w_poll_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cs     <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 8'h00;
            r_din    <= 8'h00;
            r_lcd_dc <= 1'b0;
            r_poll   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cs     <= w_cs_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_din    <= w_din_nxt;
            r_lcd_dc <= w_dc_nxt;
            r_poll   <= w_poll_nxt;
            r_err    <= r_err | w_err_set;
        end
    end

    assign s_ready   = ~w_full;
    assign cs        = r_cs;
    assign we        = r_we;
    assign addr      = r_addr;
    assign din       = r_din;
    assign lcd_dc    = r_lcd_dc;
    assign err       = r_err;
    assign busy      = ~w_empty | (r_state != S_IDLE);
    assign dbg_state = r_state;
endmodule

// File: tb/tb_lcd_spi_streamer.sv
// Directed bench for lcd_spi_streamer with a register-level SB_SPI model and a bus access log.
module tb_lcd_spi_streamer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_dc = 1'b0, s_last = 1'b0, s_valid = 1'b0;
    logic       s_ready, cs, we, lcd_dc, busy, err;
    logic [7:0] addr, din, dout;
    logic       rdy = 1'b0;
    logic [3:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // SB_SPI model controls
    logic rdy_en = 1'b1;
    logic stuck = 1'b0;
    int   tx_busy = 1;
    int   busy_reads = 1;

    // access log: {we, addr, wdata-or-0}, plus lcd_dc and read data at completion
    logic [16:0] log_q[$];
    logic        log_dc_q[$];
    logic [7:0]  log_rd_q[$];
    int          proto_err = 0;
    int          cs_hi = 0;
    logic        prev_cs = 1'b0, prev_done = 1'b0;
    logic [16:0] prev_bus = '0;

    localparam logic [16:0] RD = {1'b0, 8'h0C, 8'h00};

    lcd_spi_streamer dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_dc(s_dc), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready), .cs(cs), .we(we), .addr(addr), .din(din),
        .dout(dout), .rdy(rdy), .lcd_dc(lcd_dc), .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign dout = (stuck || busy_reads > 0) ? 8'h80 : 8'h10;

    always @(posedge clk) begin
        if (rst) begin
            rdy        <= 1'b0;
            busy_reads <= 1;
        end else begin
            rdy <= cs && !rdy && rdy_en;
            if (cs && rdy) begin
                log_q.push_back({we, addr, we ? din : 8'h00});
                log_dc_q.push_back(lcd_dc);
                log_rd_q.push_back(dout);
                if (we && addr == 8'h0D) busy_reads <= tx_busy;
                else if (!we && addr == 8'h0C && busy_reads > 0) busy_reads <= busy_reads - 1;
            end
        end
        if (prev_cs === 1'b1 && cs === 1'b1 && !prev_done && {we, addr, din} !== prev_bus)
            proto_err <= proto_err + 1;
        if (prev_done && cs === 1'b1) proto_err <= proto_err + 1;
        if (cs === 1'b1) cs_hi <= cs_hi + 1;
        prev_cs   <= cs;
        prev_done <= (cs === 1'b1) && rdy;
        prev_bus  <= {we, addr, din};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] wr(input logic [7:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    task automatic do_reset;
        @(negedge clk); rst = 1'b1; s_valid = 1'b0;
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic dc, input logic last, output logic acc);
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_dc = dc; s_last = last;
        acc = s_ready;
    endtask

    task automatic push_end;
        @(negedge clk); s_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (log_q.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++; if (cs !== 1'b0)     begin n_err++; $display("FAIL reset_cs: got %b expected 0", cs); end
        n_cmp++; if (we !== 1'b0)     begin n_err++; $display("FAIL reset_we: got %b expected 0", we); end
        n_cmp++; if (addr !== 8'h00)  begin n_err++; $display("FAIL reset_addr: got %h expected 00", addr); end
        n_cmp++; if (din !== 8'h00)   begin n_err++; $display("FAIL reset_din: got %h expected 00", din); end
        n_cmp++; if (lcd_dc !== 1'b0) begin n_err++; $display("FAIL reset_lcd_dc: got %b expected 0", lcd_dc); end
        n_cmp++; if (err !== 1'b0)    begin n_err++; $display("FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        n_cmp++; if (dbg_state !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_burst;
        logic [16:0] exp_q[$];
        logic exp_dc[$];
        int base;
        logic acc;
        bit ok;
        tx_busy = 1; rdy_en = 1'b1; stuck = 1'b0;
        do_reset;
        base = log_q.size();
        push(8'h2A, 1'b0, 1'b0, acc);
        push(8'h00, 1'b1, 1'b0, acc);
        push(8'h7F, 1'b1, 1'b1, acc);
        push_end;
        exp_q.push_back(wr(8'h0F, 8'hFE)); exp_q.push_back(RD); exp_q.push_back(RD);
        exp_q.push_back(wr(8'h0D, 8'h2A)); exp_q.push_back(RD); exp_q.push_back(RD);
        exp_q.push_back(RD); exp_q.push_back(wr(8'h0D, 8'h00)); exp_q.push_back(RD);
        exp_q.push_back(RD); exp_q.push_back(wr(8'h0D, 8'h7F)); exp_q.push_back(RD);
        exp_q.push_back(RD); exp_q.push_back(wr(8'h0F, 8'hFF));
        for (int i = 0; i < 14; i++) exp_dc.push_back(i >= 6);
        wait_log(base + 14, 600, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL burst_done: got %0d accesses expected 14", log_q.size() - base); end
        if (ok) begin
            for (int i = 0; i < 14; i++) begin
                n_cmp++;
                if (log_q[base+i] !== exp_q[i]) begin
                    n_err++; $display("FAIL burst_seq[%0d]: got %h expected %h", i, log_q[base+i], exp_q[i]);
                end
                n_cmp++;
                if (log_dc_q[base+i] !== exp_dc[i]) begin
                    n_err++; $display("FAIL burst_dc[%0d]: got %b expected %b", i, log_dc_q[base+i], exp_dc[i]);
                end
            end
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (log_q.size() != base + 14) begin n_err++; $display("FAIL burst_count: got %0d expected 14", log_q.size() - base); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_busy: got %b expected 0", busy); end
    endtask

    task automatic test_fill;
        logic [16:0] exp_q[$];
        int base, n_bad;
        logic acc;
        bit ok;
        tx_busy = 0; rdy_en = 1'b0; stuck = 1'b0;
        do_reset;
        base = log_q.size();
        n_bad = 0;
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h40 + i), 1'b1, (i == 15), acc);
            if (acc !== 1'b1) n_bad++;
        end
        n_cmp++; if (n_bad != 0) begin n_err++; $display("FAIL fill_accept: got %0d refused expected 0", n_bad); end
        push(8'hEE, 1'b0, 1'b1, acc);
        n_cmp++; if (acc !== 1'b0) begin n_err++; $display("FAIL fill_full_ready: got %b expected 0", acc); end
        push_end;
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL fill_still_full: got %b expected 0", s_ready); end
        rdy_en = 1'b1;
        exp_q.push_back(wr(8'h0F, 8'hFE)); exp_q.push_back(RD); exp_q.push_back(RD); exp_q.push_back(RD);
        exp_q.push_back(wr(8'h0D, 8'h40));
        for (int i = 1; i < 16; i++) begin
            exp_q.push_back(RD); exp_q.push_back(wr(8'h0D, 8'(8'h40 + i)));
        end
        exp_q.push_back(RD); exp_q.push_back(wr(8'h0F, 8'hFF));
        wait_log(base + 37, 1000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL fill_done: got %0d accesses expected 37", log_q.size() - base); end
        if (ok) begin
            for (int i = 0; i < 37; i++) begin
                n_cmp++;
                if (log_q[base+i] !== exp_q[i]) begin
                    n_err++; $display("FAIL fill_seq[%0d]: got %h expected %h", i, log_q[base+i], exp_q[i]);
                end
            end
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (log_q.size() != base + 37) begin n_err++; $display("FAIL fill_count: got %0d expected 37", log_q.size() - base); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fill_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single;
        logic [16:0] exp_q[$];
        int base, n_tx;
        logic acc;
        bit ok;
        tx_busy = 2; rdy_en = 1'b1; stuck = 1'b0;
        do_reset;
        base = log_q.size();
        push(8'h55, 1'b1, 1'b1, acc);
        push_end;
        exp_q.push_back(wr(8'h0F, 8'hFE)); exp_q.push_back(RD); exp_q.push_back(RD); exp_q.push_back(RD);
        exp_q.push_back(wr(8'h0D, 8'h55)); exp_q.push_back(RD); exp_q.push_back(RD); exp_q.push_back(RD);
        exp_q.push_back(wr(8'h0F, 8'hFF));
        wait_log(base + 9, 400, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_done: got %0d accesses expected 9", log_q.size() - base); end
        if (ok) begin
            for (int i = 0; i < 9; i++) begin
                n_cmp++;
                if (log_q[base+i] !== exp_q[i]) begin
                    n_err++; $display("FAIL single_seq[%0d]: got %h expected %h", i, log_q[base+i], exp_q[i]);
                end
            end
            n_cmp++; if (log_rd_q[base+6] !== 8'h80) begin n_err++; $display("FAIL single_tip_busy: got %h expected 80", log_rd_q[base+6]); end
            n_cmp++; if (log_rd_q[base+7] !== 8'h10) begin n_err++; $display("FAIL single_tip_clear: got %h expected 10", log_rd_q[base+7]); end
        end
        repeat (5) @(negedge clk);
        n_tx = 0;
        for (int i = base; i < log_q.size(); i++) if (log_q[i][16:8] == 9'h10D) n_tx++;
        n_cmp++; if (n_tx != 1) begin n_err++; $display("FAIL single_tx_count: got %0d expected 1", n_tx); end
    endtask

    task automatic test_underrun;
        logic [16:0] exp_q[$];
        int base, snap_log, snap_cs;
        logic acc;
        bit ok;
        tx_busy = 1; rdy_en = 1'b1; stuck = 1'b0;
        do_reset;
        base = log_q.size();
        push(8'hA1, 1'b1, 1'b0, acc);
        push_end;
        wait_log(base + 5, 300, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL underrun_first: got %0d accesses expected 5", log_q.size() - base); end
        repeat (3) @(negedge clk);
        snap_log = log_q.size();
        snap_cs  = cs_hi;
        repeat (50) @(negedge clk);
        n_cmp++; if (log_q.size() != snap_log) begin n_err++; $display("FAIL underrun_quiet: got %0d accesses expected 0", log_q.size() - snap_log); end
        n_cmp++; if (cs_hi != snap_cs) begin n_err++; $display("FAIL underrun_cs_idle: got %0d cs cycles expected 0", cs_hi - snap_cs); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL underrun_busy: got %b expected 1", busy); end
        push(8'hB2, 1'b1, 1'b1, acc);
        push_end;
        exp_q.push_back(wr(8'h0F, 8'hFE)); exp_q.push_back(RD); exp_q.push_back(RD); exp_q.push_back(RD);
        exp_q.push_back(wr(8'h0D, 8'hA1)); exp_q.push_back(RD); exp_q.push_back(RD);
        exp_q.push_back(wr(8'h0D, 8'hB2)); exp_q.push_back(RD); exp_q.push_back(RD);
        exp_q.push_back(wr(8'h0F, 8'hFF));
        wait_log(base + 11, 400, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL underrun_done: got %0d accesses expected 11", log_q.size() - base); end
        if (ok) begin
            for (int i = 0; i < 11; i++) begin
                n_cmp++;
                if (log_q[base+i] !== exp_q[i]) begin
                    n_err++; $display("FAIL underrun_seq[%0d]: got %h expected %h", i, log_q[base+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout;
        int base, n_rd;
        logic acc;
        bit ok;
        tx_busy = 1; rdy_en = 1'b1; stuck = 1'b1;
        do_reset;
        base = log_q.size();
        push(8'h11, 1'b0, 1'b0, acc);
        push(8'h22, 1'b0, 1'b0, acc);
        push(8'h33, 1'b0, 1'b1, acc);
        push_end;
        wait_log(base + 1025, 6000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL timeout_done: got %0d accesses expected 1025", log_q.size() - base); end
        repeat (6) @(negedge clk);
        n_cmp++; if (log_q.size() != base + 1025) begin n_err++; $display("FAIL timeout_count: got %0d expected 1025", log_q.size() - base); end
        if (ok) begin
            n_rd = 0;
            for (int i = base + 1; i < base + 1024; i++) if (log_q[i] == RD) n_rd++;
            n_cmp++; if (n_rd != 1023) begin n_err++; $display("FAIL timeout_polls: got %0d expected 1023", n_rd); end
            n_cmp++; if (log_q[base] !== wr(8'h0F, 8'hFE)) begin n_err++; $display("FAIL timeout_cs_on: got %h expected 10ffe", log_q[base]); end
            n_cmp++; if (log_q[base+1024] !== wr(8'h0F, 8'hFF)) begin n_err++; $display("FAIL timeout_cs_off: got %h expected 10fff", log_q[base+1024]); end
        end
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL timeout_err: got %b expected 1", err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL timeout_flush: got busy %b expected 0", busy); end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL timeout_ready: got %b expected 1", s_ready); end
        n_cmp++; if (dbg_state !== 4'd0) begin n_err++; $display("FAIL timeout_idle: got %0d expected 0", dbg_state); end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid_access;
        logic acc;
        bit ok;
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", err); end
        rdy_en = 1'b0;
        push(8'h99, 1'b0, 1'b1, acc);
        push_end;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (cs === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL midrst_cs_up: got cs %b expected 1", cs); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (cs !== 1'b0)      begin n_err++; $display("FAIL midrst_cs: got %b expected 0", cs); end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", s_ready); end
        n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_cmp++; if (err !== 1'b0)     begin n_err++; $display("FAIL midrst_err: got %b expected 0", err); end
        rst = 1'b0;
        rdy_en = 1'b1;
    endtask

    initial begin
        test_reset;
        test_burst;
        test_fill;
        test_single;
        test_underrun;
        test_timeout;
        test_reset_mid_access;
        repeat (3) @(negedge clk);
        n_cmp++; if (proto_err != 0) begin n_err++; $display("FAIL bus_protocol: got %0d violations expected 0", proto_err); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
